// File: rtl/var_delay_line.sv
// Runtime-selectable multi-lane delay line with valid tagging and clock enable.
// A delay change suppresses dout_vld until the line has refilled at the new depth.
module var_delay_line #(
   parameter int MAX_DLY = 16,
   parameter int DW      = 8,
   parameter int NCH     = 1,
   parameter int DSW     = $clog2(MAX_DLY + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [DSW-1:0]      dly_sel,
   input  logic                din_vld,
   input  logic [NCH*DW-1:0]   din,
   output logic                dout_vld,
   output logic [NCH*DW-1:0]   dout,
   output logic                busy
);

   localparam int W = NCH * DW + 1;

   typedef enum logic {RUN, REFILL} state_t;

   state_t         state, state_next;
   logic [DSW-1:0] cur_dly, cur_dly_next;
   logic [DSW-1:0] fill_cnt, fill_cnt_next;
   logic [DSW-1:0] eff_dly;
   logic [W-1:0]   stage [MAX_DLY];
   logic [W-1:0]   tap;

   always_comb begin
      eff_dly = dly_sel;
      if (dly_sel == '0)
         eff_dly = DSW'(1);
      else if (dly_sel > DSW'(MAX_DLY))
         eff_dly = DSW'(MAX_DLY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAX_DLY; i++)
            stage[i] <= '0;
      end else if (en) begin
         stage[0] <= {din_vld, din};
         for (int i = 1; i < MAX_DLY; i++)
            stage[i] <= stage[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         cur_dly  <= eff_dly;
         fill_cnt <= '0;
      end else begin
         state    <= state_next;
         cur_dly  <= cur_dly_next;
         fill_cnt <= fill_cnt_next;
      end
   end

   // A new delay always restarts the refill, even if one is already in progress.
   always_comb begin
      state_next    = state;
      cur_dly_next  = cur_dly;
      fill_cnt_next = fill_cnt;
      if (eff_dly != cur_dly) begin
         state_next    = REFILL;
         cur_dly_next  = eff_dly;
         fill_cnt_next = '0;
      end else if (state == REFILL && en) begin
         if (fill_cnt == cur_dly - DSW'(1))
            state_next = RUN;
         else
            fill_cnt_next = fill_cnt + DSW'(1);
      end
   end

   // Compare-based mux keeps the index width independent of MAX_DLY.
   always_comb begin
      tap = stage[0];
      for (int i = 0; i < MAX_DLY; i++) begin
         if (cur_dly == DSW'(i + 1))
            tap = stage[i];
      end
   end

   assign dout     = tap[W-2:0];
   assign dout_vld = tap[W-1] && (state == RUN);
   assign busy     = (state == REFILL);

endmodule

// File: tb/tb_var_delay_line.sv
// Bench for var_delay_line: table vectors, directed corner sequences and a
// randomized run, all checked against a sample-history reference model.
module tb_var_delay_line;

   localparam int MAX_DLY = 16;
   localparam int DW      = 8;
   localparam int NCH     = 2;
   localparam int DSW     = $clog2(MAX_DLY + 1);
   localparam int W       = NCH * DW;

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic [DSW-1:0] dly_sel;
   logic           din_vld;
   logic [W-1:0]   din;
   logic           dout_vld;
   logic [W-1:0]   dout;
   logic           busy;

   var_delay_line #(
      .MAX_DLY (MAX_DLY),
      .DW      (DW),
      .NCH     (NCH),
      .DSW     (DSW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .dly_sel  (dly_sel),
      .din_vld  (din_vld),
      .din      (din),
      .dout_vld (dout_vld),
      .dout     (dout),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Reference: the last MAX_DLY accepted samples, newest first, plus how many
   // enabled edges of refill remain before the output is trusted again.
   logic [W:0] hist [MAX_DLY];
   int         m_dly;
   int         m_left;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic           rst;
      logic           en;
      logic [DSW-1:0] sel;
      logic           vld;
      logic [W-1:0]   din;
      logic           exp_vld;
      logic [W-1:0]   exp_dout;
      logic           exp_busy;
   } vec_t;

   vec_t tbl [10];

   function automatic int clamp_dly(input int s);
      if (s == 0) return 1;
      if (s > MAX_DLY) return MAX_DLY;
      return s;
   endfunction

   task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic e, input logic [DSW-1:0] s,
                             input logic v, input logic [W-1:0] d);
      int want;
      want = clamp_dly(int'(s));
      if (r) begin
         for (int i = 0; i < MAX_DLY; i++) hist[i] = '0;
         m_dly  = want;
         m_left = 0;
      end else begin
         if (want != m_dly) begin
            m_dly  = want;
            m_left = want;
         end else if (e && m_left > 0) begin
            m_left--;
         end
         if (e) begin
            for (int i = MAX_DLY - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {v, d};
         end
      end
   endtask

   task automatic apply_stimulus(input logic r, input logic e, input logic [DSW-1:0] s,
                                 input logic v, input logic [W-1:0] d);
      logic [W:0] t;
      rst = r; en = e; dly_sel = s; din_vld = v; din = d;
      @(posedge clk);
      model_edge(r, e, s, v, d);
      #1;
      t = hist[m_dly-1];
      check_output("model_busy", W'(busy), W'(m_left > 0));
      check_output("model_vld", W'(dout_vld), W'(t[W] && m_left == 0));
      check_output("model_dout", dout, t[W-1:0]);
   endtask

   task automatic run_cycles(input int n, input logic [DSW-1:0] s);
      for (int i = 0; i < n; i++)
         apply_stimulus(1'b0, 1'b1, s, 1'($urandom_range(0, 1)), W'($urandom));
   endtask

   task automatic count_busy(input logic [DSW-1:0] s, output int c);
      c = 0;
      apply_stimulus(1'b0, 1'b1, s, 1'b1, W'($urandom));
      while (busy === 1'b1 && c < 40) begin
         c++;
         apply_stimulus(1'b0, 1'b1, s, 1'b1, W'($urandom));
      end
   endtask

   initial begin
      logic [W-1:0] held_dout;
      logic         held_vld;
      logic [7:0]   lo, hi;
      int           c;

      rst = 1'b1; en = 1'b0; dly_sel = '0; din_vld = 1'b0; din = '0;
      for (int i = 0; i < MAX_DLY; i++) hist[i] = '0;
      m_dly = 1; m_left = 0;

      // rst, en, sel, vld, din, exp_vld, exp_dout, exp_busy
      tbl[0] = '{1'b1, 1'b0, 5'd0,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 5'd0,  1'b1, 16'h1111, 1'b1, 16'h1111, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 5'd1,  1'b0, 16'h2222, 1'b0, 16'h2222, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 5'd0,  1'b1, 16'h3333, 1'b0, 16'h2222, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 5'd1,  1'b1, 16'h4444, 1'b1, 16'h4444, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 5'd2,  1'b1, 16'h5555, 1'b0, 16'h4444, 1'b1};
      tbl[6] = '{1'b0, 1'b1, 5'd2,  1'b1, 16'h6666, 1'b0, 16'h5555, 1'b1};
      tbl[7] = '{1'b0, 1'b1, 5'd2,  1'b1, 16'h7777, 1'b1, 16'h6666, 1'b0};
      tbl[8] = '{1'b1, 1'b1, 5'd20, 1'b1, 16'h8888, 1'b0, 16'h0000, 1'b0};
      tbl[9] = '{1'b0, 1'b1, 5'd20, 1'b1, 16'h9999, 1'b0, 16'h0000, 1'b0};

      for (int i = 0; i < 10; i++) begin
         apply_stimulus(tbl[i].rst, tbl[i].en, tbl[i].sel, tbl[i].vld, tbl[i].din);
         check_output($sformatf("tbl%0d_vld", i), W'(dout_vld), W'(tbl[i].exp_vld));
         check_output($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
         check_output($sformatf("tbl%0d_busy", i), W'(busy), W'(tbl[i].exp_busy));
      end

      // Clamped select 20 -> 16: a sample needs 16 edges, and no busy appears.
      apply_stimulus(1'b0, 1'b1, 5'd31, 1'b1, 16'hC0DE);
      for (int i = 0; i < 15; i++) begin
         apply_stimulus(1'b0, 1'b1, 5'd17, 1'b0, 16'h0000);
         check_output("clamp_busy", W'(busy), W'(1'b0));
      end
      check_output("clamp16_dout", dout, 16'hC0DE);
      check_output("clamp16_vld", W'(dout_vld), W'(1'b1));

      // Fixed delay of 5 with two lanes {A0+k, k}.
      apply_stimulus(1'b1, 1'b1, 5'd5, 1'b0, '0);
      for (int k = 0; k < 20; k++) begin
         lo = 8'(k); hi = 8'hA0 + 8'(k);
         apply_stimulus(1'b0, 1'b1, 5'd5, 1'b1, {hi, lo});
         check_output($sformatf("fixed_vld_k%0d", k), W'(dout_vld), W'(k >= 4));
         if (k >= 4) begin
            lo = 8'(k - 4); hi = 8'hA0 + 8'(k - 4);
            check_output($sformatf("fixed_dout_k%0d", k), dout, {hi, lo});
         end
      end

      // Bubbles and stall at delay 3.
      apply_stimulus(1'b1, 1'b1, 5'd3, 1'b0, '0);
      apply_stimulus(1'b0, 1'b1, 5'd3, 1'b1, 16'h0101);
      apply_stimulus(1'b0, 1'b1, 5'd3, 1'b0, 16'h0202);
      held_dout = dout; held_vld = dout_vld;
      for (int i = 0; i < 2; i++) begin
         apply_stimulus(1'b0, 1'b0, 5'd3, 1'b1, 16'h0303);
         check_output("stall_dout", dout, held_dout);
         check_output("stall_vld", W'(dout_vld), W'(held_vld));
      end
      apply_stimulus(1'b0, 1'b1, 5'd3, 1'b1, 16'h0505);
      check_output("bubble_first_dout", dout, 16'h0101);
      check_output("bubble_first_vld", W'(dout_vld), W'(1'b1));
      apply_stimulus(1'b0, 1'b1, 5'd3, 1'b1, 16'h0606);
      check_output("bubble_gap_vld", W'(dout_vld), W'(1'b0));
      apply_stimulus(1'b0, 1'b1, 5'd3, 1'b0, 16'h0000);
      check_output("bubble_third_dout", dout, 16'h0505);
      run_cycles(4, 5'd3);

      // Delay changes 4 -> 7 -> 2.
      apply_stimulus(1'b1, 1'b1, 5'd4, 1'b0, '0);
      run_cycles(8, 5'd4);
      count_busy(5'd7, c);
      check_output("busy_len_4to7", W'(c), W'(7));
      run_cycles(10, 5'd7);
      count_busy(5'd2, c);
      check_output("busy_len_7to2", W'(c), W'(2));
      run_cycles(6, 5'd2);

      // Change during refill: 4 -> 8, then 8 -> 3 after two enabled edges.
      run_cycles(6, 5'd4);
      apply_stimulus(1'b0, 1'b1, 5'd8, 1'b1, W'($urandom));
      apply_stimulus(1'b0, 1'b1, 5'd8, 1'b1, W'($urandom));
      count_busy(5'd3, c);
      check_output("busy_len_restart", W'(c), W'(3));
      run_cycles(6, 5'd3);

      // Reset while full and refilling.
      run_cycles(20, 5'd8);
      apply_stimulus(1'b0, 1'b1, 5'd12, 1'b1, W'($urandom));
      apply_stimulus(1'b1, 1'b1, 5'd12, 1'b1, 16'hFFFF);
      check_output("rst_vld", W'(dout_vld), W'(1'b0));
      check_output("rst_dout", dout, '0);
      check_output("rst_busy", W'(busy), W'(1'b0));
      run_cycles(16, 5'd12);

      // Randomized run with occasional stalls, select changes and resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) dly_sel = DSW'($urandom_range(0, 31));
         apply_stimulus(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 4) != 0),
                        dly_sel, 1'($urandom_range(0, 1)), W'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
